// File: rtl/rv_pkg.sv
// Shared types and constants for the RV32I decode stage.
//   Opcodes, ALU/result-select encodings, immediate formats,
//   the ID/EX control bundle and the full ID/EX payload.
package rv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J,
    IMM_NONE
  } imm_type_t;

  typedef struct packed {
    logic        regwrite;
    logic        memwrite;
    logic        jump;
    logic        branch;
    logic        alusrc;
    result_src_t resultsrc;
    alu_op_t     alucontrol;
    logic        illegal;
  } ctrl_t;

  typedef struct packed {
    ctrl_t             ctrl;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pcplus4;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
  } idex_t;

  // funct3 (plus the sub/add selector bit for R-type) to ALU operation
  function automatic alu_op_t alu_decode(input logic [2:0] funct3, input logic sub_bit);
    alu_op_t op;
    case (funct3)
      3'b000:  op = sub_bit ? ALU_SUB : ALU_ADD;
      3'b010:  op = ALU_SLT;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // Sign-extended immediate from instruction bits [31:7]
  function automatic logic [XLEN-1:0] imm_ext(input logic [31:7] ins, input imm_type_t t);
    logic [XLEN-1:0] imm;
    case (t)
      IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_cycle_register_file.sv
// 32x32 register file: two async read ports, one sync write port.
//   a1/a2 -> rd1/rd2 : read addresses/data (x0 reads 0, same-cycle WB bypass)
//   a3/we3/wd3       : write address/enable/data (writes to x0 dropped)
//   rst              : asynchronous active-low clear of all registers
module register_file
  import rv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] a1,
  input  logic [REG_AW-1:0] a2,
  input  logic [REG_AW-1:0] a3,
  input  logic              we3,
  input  logic [XLEN-1:0]   wd3,
  output logic [XLEN-1:0]   rd1,
  output logic [XLEN-1:0]   rd2
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic            wr_en;

  assign wr_en = we3 && (a3 != '0);

  // Write port; x0 is never written so it stays zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[a3] <= wd3;
    end
  end

  // Read ports with write-through of the value being written this cycle
  assign rd1 = (a1 == '0) ? '0 : ((wr_en && (a1 == a3)) ? wd3 : regs_q[a1]);
  assign rd2 = (a2 == '0) ? '0 : ((wr_en && (a2 == a3)) ? wd3 : regs_q[a2]);

endmodule

// File: rtl/decode_cycle.sv
// RV32I ID stage: decode, register read, immediate build, ID/EX register.
//   instrd/pcd/pcplus4D : IF/ID inputs
//   pcsrc               : redirect from EX, squashes the next ID/EX entry
//   regwritew/rdw/resultw : writeback port into the register file
//   stall_d             : combinational load-use stall back to fetch
//   *e outputs          : registered ID/EX contents
module decode_cycle
  import rv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   instrd,
  input  logic [XLEN-1:0]   pcd,
  input  logic [XLEN-1:0]   pcplus4D,
  input  logic              pcsrc,
  input  logic              regwritew,
  input  logic [REG_AW-1:0] rdw,
  input  logic [XLEN-1:0]   resultw,
  output logic              stall_d,
  output logic              regwritee,
  output logic              memwritee,
  output logic              jumpe,
  output logic              branche,
  output logic              alusrce,
  output logic [1:0]        resultsrce,
  output logic [2:0]        alucontrole,
  output logic              illegale,
  output logic [XLEN-1:0]   rd1e,
  output logic [XLEN-1:0]   rd2e,
  output logic [XLEN-1:0]   imme,
  output logic [XLEN-1:0]   pce,
  output logic [XLEN-1:0]   pcplus4e,
  output logic [REG_AW-1:0] rs1e,
  output logic [REG_AW-1:0] rs2e,
  output logic [REG_AW-1:0] rde
);

  logic [6:0]        opcode_c;
  logic [2:0]        funct3_c;
  logic [REG_AW-1:0] rs1_c, rs2_c, rd_c;
  logic [XLEN-1:0]   rd1_c, rd2_c;
  ctrl_t             ctrl_c;
  imm_type_t         imm_type_c;
  idex_t             idex_d, idex_q;

  assign opcode_c = instrd[6:0];
  assign funct3_c = instrd[14:12];
  assign rd_c     = instrd[11:7];
  assign rs1_c    = instrd[19:15];
  assign rs2_c    = instrd[24:20];

  register_file u_rf (
    .clk (clk),
    .rst (rst),
    .a1  (rs1_c),
    .a2  (rs2_c),
    .a3  (rdw),
    .we3 (regwritew),
    .wd3 (resultw),
    .rd1 (rd1_c),
    .rd2 (rd2_c)
  );

  // Main decoder
  always_comb begin
    ctrl_c     = '0;
    imm_type_c = IMM_NONE;
    case (opcode_c)
      OP_LOAD: begin
        ctrl_c.regwrite  = 1'b1;
        ctrl_c.alusrc    = 1'b1;
        ctrl_c.resultsrc = RES_MEM;
        imm_type_c       = IMM_I;
      end
      OP_STORE: begin
        ctrl_c.memwrite = 1'b1;
        ctrl_c.alusrc   = 1'b1;
        imm_type_c      = IMM_S;
      end
      OP_R: begin
        ctrl_c.regwrite   = 1'b1;
        ctrl_c.alucontrol = alu_decode(funct3_c, instrd[30]);
      end
      OP_IALU: begin
        ctrl_c.regwrite   = 1'b1;
        ctrl_c.alusrc     = 1'b1;
        ctrl_c.alucontrol = alu_decode(funct3_c, 1'b0);
        imm_type_c        = IMM_I;
      end
      OP_BEQ: begin
        ctrl_c.branch     = 1'b1;
        ctrl_c.alucontrol = ALU_SUB;
        imm_type_c        = IMM_B;
      end
      OP_JAL: begin
        ctrl_c.regwrite  = 1'b1;
        ctrl_c.jump      = 1'b1;
        ctrl_c.resultsrc = RES_PC4;
        imm_type_c       = IMM_J;
      end
      // All-zero word is the natural bubble and is not flagged
      default: ctrl_c.illegal = (instrd != '0);
    endcase
  end

  // Load-use hazard against the load currently sitting in ID/EX
  assign stall_d = (idex_q.ctrl.resultsrc == RES_MEM) && (idex_q.rd != '0) &&
                   ((idex_q.rd == rs1_c) || (idex_q.rd == rs2_c));

  // Next ID/EX entry; flush and stall both insert an all-zero bubble
  always_comb begin
    idex_d         = '0;
    idex_d.ctrl    = ctrl_c;
    idex_d.rd1     = rd1_c;
    idex_d.rd2     = rd2_c;
    idex_d.imm     = imm_ext(instrd[31:7], imm_type_c);
    idex_d.pc      = pcd;
    idex_d.pcplus4 = pcplus4D;
    idex_d.rs1     = rs1_c;
    idex_d.rs2     = rs2_c;
    idex_d.rd      = rd_c;
    if (pcsrc || stall_d) idex_d = '0;
  end

  // ID/EX register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idex_q <= '0;
    else      idex_q <= idex_d;
  end

  assign regwritee   = idex_q.ctrl.regwrite;
  assign memwritee   = idex_q.ctrl.memwrite;
  assign jumpe       = idex_q.ctrl.jump;
  assign branche     = idex_q.ctrl.branch;
  assign alusrce     = idex_q.ctrl.alusrc;
  assign resultsrce  = idex_q.ctrl.resultsrc;
  assign alucontrole = idex_q.ctrl.alucontrol;
  assign illegale    = idex_q.ctrl.illegal;
  assign rd1e        = idex_q.rd1;
  assign rd2e        = idex_q.rd2;
  assign imme        = idex_q.imm;
  assign pce         = idex_q.pc;
  assign pcplus4e    = idex_q.pcplus4;
  assign rs1e        = idex_q.rs1;
  assign rs2e        = idex_q.rs2;
  assign rde         = idex_q.rd;

endmodule

// File: tb/tb_decode_cycle.sv
// Scoreboard bench for decode_cycle: stimulus pushes expected ID/EX words
// and stall values tagged with the cycle they must appear in; a negedge
// monitor pops and compares them.
module tb_decode_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instrd, pcd, pcplus4D, resultw;
  logic        pcsrc, regwritew;
  logic [4:0]  rdw;
  logic        stall_d, regwritee, memwritee, jumpe, branche, alusrce, illegale;
  logic [1:0]  resultsrce;
  logic [2:0]  alucontrole;
  logic [31:0] rd1e, rd2e, imme, pce, pcplus4e;
  logic [4:0]  rs1e, rs2e, rde;

  always #5 clk = ~clk;

  decode_cycle dut (
    .clk(clk), .rst(rst), .instrd(instrd), .pcd(pcd), .pcplus4D(pcplus4D),
    .pcsrc(pcsrc), .regwritew(regwritew), .rdw(rdw), .resultw(resultw),
    .stall_d(stall_d), .regwritee(regwritee), .memwritee(memwritee),
    .jumpe(jumpe), .branche(branche), .alusrce(alusrce), .resultsrce(resultsrce),
    .alucontrole(alucontrole), .illegale(illegale), .rd1e(rd1e), .rd2e(rd2e),
    .imme(imme), .pce(pce), .pcplus4e(pcplus4e), .rs1e(rs1e), .rs2e(rs2e), .rde(rde)
  );

  // {rw,mw,jump,branch,alusrc,resultsrc[1:0],alu[2:0],illegal}
  localparam logic [10:0] C_ADDI = 11'b10001_00_000_0;
  localparam logic [10:0] C_ADD  = 11'b10000_00_000_0;
  localparam logic [10:0] C_SUB  = 11'b10000_00_001_0;
  localparam logic [10:0] C_AND  = 11'b10000_00_010_0;
  localparam logic [10:0] C_ORI  = 11'b10001_00_011_0;
  localparam logic [10:0] C_SLTI = 11'b10001_00_101_0;
  localparam logic [10:0] C_LW   = 11'b10001_01_000_0;
  localparam logic [10:0] C_SW   = 11'b01001_00_000_0;
  localparam logic [10:0] C_BEQ  = 11'b00010_00_001_0;
  localparam logic [10:0] C_JAL  = 11'b10100_10_000_0;
  localparam logic [10:0] C_ILL  = 11'b00000_00_000_1;
  localparam logic [185:0] BUBBLE = '0;

  typedef struct {
    int             tgt;
    string          nm;
    logic [185:0]   v;
  } item_t;

  item_t q[$];
  item_t it;
  int    cyc = 0;
  int    total = 0;
  int    bad = 0;
  logic [185:0] dut_v;

  assign dut_v = {regwritee, memwritee, jumpe, branche, alusrce, resultsrce,
                  alucontrole, illegale, rd1e, rd2e, imme, pce, pcplus4e,
                  rs1e, rs2e, rde};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [185:0] ev(input logic [10:0] c, input logic [31:0] r1, r2, im, pc,
                                      input logic [4:0] s1, s2, d);
    return {c, r1, r2, im, pc, pc + 32'd4, s1, s2, d};
  endfunction

  task automatic chk(input string nm, input logic [185:0] act, input logic [185:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Drive one ID-stage cycle and schedule its expected outcomes
  task automatic issue(input string nm, input logic [31:0] ins, input logic [31:0] pc,
                       input logic flush, input logic we, input logic [4:0] wrd,
                       input logic [31:0] wdata, input logic [185:0] exp_idex,
                       input logic exp_stall);
    item_t s, e;
    instrd = ins; pcd = pc; pcplus4D = pc + 32'd4; pcsrc = flush;
    regwritew = we; rdw = wrd; resultw = wdata;
    s.tgt = cyc;     s.nm = {nm, "_stall"}; s.v = 186'(exp_stall);
    e.tgt = cyc + 1; e.nm = {nm, "_idex"};  e.v = exp_idex;
    q.push_back(s);
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  // Monitor: compare every entry due this cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].tgt <= cyc) begin
      it = q.pop_front();
      if (it.tgt < cyc) chk({it.nm, "_late"}, 186'(cyc), 186'(it.tgt));
      else if (it.nm.len() > 6 && it.nm.substr(it.nm.len() - 6, it.nm.len() - 1) == "_stall")
        chk(it.nm, 186'(stall_d), it.v);
      else
        chk(it.nm, dut_v, it.v);
    end
  end

  initial begin
    rst = 1'b0; pcsrc = 1'b0; regwritew = 1'b0; rdw = '0; resultw = '0;
    instrd = '0; pcd = '0; pcplus4D = '0;
    // Reset held with random inputs
    repeat (3) begin
      @(posedge clk); #1;
      instrd = $urandom; pcd = $urandom; pcplus4D = $urandom; pcsrc = 1'($urandom);
      regwritew = 1'($urandom); rdw = 5'($urandom); resultw = $urandom;
      #2;
      chk("reset_idex", dut_v, BUBBLE);
      chk("reset_stall", 186'(stall_d), 186'(0));
    end
    instrd = '0; pcsrc = 1'b0; regwritew = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    issue("addi",     32'h00500093, 32'h100, 0, 0, 0, 0, ev(C_ADDI, 0, 0, 5, 32'h100, 0, 5, 1), 0);
    issue("add_byp",  32'h00108133, 32'h104, 0, 1, 1, 5, ev(C_ADD, 5, 5, 0, 32'h104, 1, 1, 2), 0);
    issue("x0_wr",    32'h00000033, 32'h108, 0, 1, 0, 32'hFFFF_FFFF, ev(C_ADD, 0, 0, 0, 32'h108, 0, 0, 0), 0);
    issue("lw",       32'h00802283, 32'h10C, 0, 0, 0, 0, ev(C_LW, 0, 0, 8, 32'h10C, 0, 8, 5), 0);
    issue("lu_stall", 32'h00528333, 32'h110, 0, 0, 0, 0, BUBBLE, 1);
    issue("lu_retry", 32'h00528333, 32'h110, 0, 1, 5, 32'h2A, ev(C_ADD, 32'h2A, 32'h2A, 0, 32'h110, 5, 5, 6), 0);
    issue("beq",      32'hFE000CE3, 32'h114, 0, 0, 0, 0, ev(C_BEQ, 0, 0, 32'hFFFF_FFF8, 32'h114, 0, 0, 25), 0);
    issue("jal",      32'h001000EF, 32'h118, 0, 0, 0, 0, ev(C_JAL, 0, 5, 32'h800, 32'h118, 0, 1, 1), 0);
    issue("lw2",      32'h00802283, 32'h11C, 0, 0, 0, 0, ev(C_LW, 0, 0, 8, 32'h11C, 0, 8, 5), 0);
    issue("flush_st", 32'h00528333, 32'h120, 1, 0, 0, 0, BUBBLE, 1);
    issue("illegal",  32'h0000007F, 32'h124, 0, 0, 0, 0, ev(C_ILL, 0, 0, 0, 32'h124, 0, 0, 0), 0);
    issue("flush",    32'h00708193, 32'h128, 1, 0, 0, 0, BUBBLE, 0);
    issue("sub",      32'h405083B3, 32'h12C, 0, 0, 0, 0, ev(C_SUB, 5, 32'h2A, 0, 32'h12C, 1, 5, 7), 0);
    issue("slti",     32'hFFF0A413, 32'h130, 0, 0, 0, 0, ev(C_SLTI, 5, 0, 32'hFFFF_FFFF, 32'h130, 1, 31, 8), 0);
    issue("sw",       32'h0050A623, 32'h134, 0, 0, 0, 0, ev(C_SW, 5, 32'h2A, 12, 32'h134, 1, 5, 12), 0);
    issue("and",      32'h0050F4B3, 32'h138, 0, 0, 0, 0, ev(C_AND, 5, 32'h2A, 0, 32'h138, 1, 5, 9), 0);
    issue("ori",      32'h0030E513, 32'h13C, 0, 0, 0, 0, ev(C_ORI, 5, 0, 3, 32'h13C, 1, 3, 10), 0);

    // Asynchronous reset between edges
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    chk("async_rst_idex", dut_v, BUBBLE);
    chk("async_rst_stall", 186'(stall_d), 186'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    issue("post_rst", 32'h00108133, 32'h140, 0, 0, 0, 0, ev(C_ADD, 0, 0, 0, 32'h140, 1, 1, 2), 0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 186'(q.size()), 186'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound
  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
